// File: rtl/fetch_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_seq_pkg                                                        |
// | Shared state type and constants for the program sequencer.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fetch_seq_pkg;

  typedef enum logic [1:0] {FS_IDLE, FS_RUN, FS_HALT} fetch_state_t;

  localparam int PC_W_DEFAULT = 10;
  localparam logic [1:0] PCSEL_NONE = 2'b00;

endpackage
`default_nettype wire

// File: rtl/fetch_seq_pc_save_file.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_seq_pc_save_file                                               |
// | Three jump-target save registers with one write and one read port.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_seq_pc_save_file
  import fetch_seq_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_wr_en,
  input  logic [1:0]      i_wr_sel,
  input  logic [PC_W-1:0] i_wr_data,
  input  logic [1:0]      i_rd_sel,
  output logic [PC_W-1:0] o_rd_data
);

  logic [PC_W-1:0] r_pcreg [1:3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= 3; i++) r_pcreg[i] <= '0;
    end else if (i_wr_en && (i_wr_sel != PCSEL_NONE)) begin
      r_pcreg[i_wr_sel] <= i_wr_data;
    end
  end

  // Selector 00 means "no register", which reads as zero.
  always_comb begin
    o_rd_data = '0;
    if (i_rd_sel != PCSEL_NONE) o_rd_data = r_pcreg[i_rd_sel];
  end

endmodule
`default_nettype wire

// File: rtl/fetch_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_seq                                                            |
// | Program sequencer: PC, jump/save handling, start/done handshake.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int PC_W  = PC_W_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Ack,
  input  logic             JumpEqual,
  input  logic             JumpNotEqual,
  input  logic             OffsetEn,
  input  logic [1:0]       PCRegSelect,
  input  logic [7:0]       OffsetData,
  input  logic             ZeroFlag,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] InstCount
);

  localparam logic [1:0] C_ST_IDLE = 2'(FS_IDLE);
  localparam logic [1:0] C_ST_RUN  = 2'(FS_RUN);
  localparam logic [1:0] C_ST_HALT = 2'(FS_HALT);

  logic [1:0]       r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;

  logic             w_run;
  logic             w_start;
  logic             w_sel_nz;
  logic             w_taken;
  logic             w_jump;
  logic             w_save;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_offset;
  logic [PC_W-1:0]  w_save_data;
  logic [PC_W-1:0]  w_target;

  assign w_run    = (r_state == C_ST_RUN);
  assign w_start  = Start && !w_run;
  assign w_sel_nz = (PCRegSelect != PCSEL_NONE);
  assign w_taken  = (JumpEqual && ZeroFlag) || (JumpNotEqual && !ZeroFlag);

  // Any je/jne blocks a save even when the jump itself is not taken.
  assign w_jump = w_run && !Ack && w_sel_nz && w_taken;
  assign w_save = w_run && !Ack && w_sel_nz && !JumpEqual && !JumpNotEqual;

  assign w_pc_inc    = r_pc + PC_W'(1);
  assign w_offset    = OffsetEn ? PC_W'(OffsetData) : '0;
  assign w_save_data = w_pc_inc + w_offset;

  fetch_seq_pc_save_file #(
    .PC_W (PC_W)
  ) u_save (
    .clk       (Clk),
    .rst_n     (ResetN),
    .i_wr_en   (w_save),
    .i_wr_sel  (PCRegSelect),
    .i_wr_data (w_save_data),
    .i_rd_sel  (PCRegSelect),
    .o_rd_data (w_target)
  );

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= C_ST_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        C_ST_IDLE, C_ST_HALT: begin
          if (w_start) begin
            r_state <= C_ST_RUN;
            r_pc    <= StartAddr;
            r_cnt   <= '0;
          end
        end
        C_ST_RUN: begin
          if (Ack) begin
            r_state <= C_ST_HALT;
          end else begin
            r_pc <= w_jump ? w_target : w_pc_inc;
            if (!(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= C_ST_IDLE;
      endcase
    end
  end

  assign ProgCtr   = r_pc;
  assign InstCount = r_cnt;
  assign Busy      = (r_state == C_ST_RUN);
  assign Done      = (r_state == C_ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_seq                                                         |
// | Self-checking bench for fetch_seq with a behavioural reference model.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fetch_seq;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             ResetN;
  logic             Start;
  logic [PC_W-1:0]  StartAddr;
  logic             Ack;
  logic             JumpEqual;
  logic             JumpNotEqual;
  logic             OffsetEn;
  logic [1:0]       PCRegSelect;
  logic [7:0]       OffsetData;
  logic             ZeroFlag;
  logic [PC_W-1:0]  ProgCtr;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] InstCount;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 running, 2 halted
  int          m_state;
  int unsigned m_pc;
  int unsigned m_cnt;
  int unsigned m_reg [4];

  fetch_seq #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .Clk          (Clk),
    .ResetN       (ResetN),
    .Start        (Start),
    .StartAddr    (StartAddr),
    .Ack          (Ack),
    .JumpEqual    (JumpEqual),
    .JumpNotEqual (JumpNotEqual),
    .OffsetEn     (OffsetEn),
    .PCRegSelect  (PCRegSelect),
    .OffsetData   (OffsetData),
    .ZeroFlag     (ZeroFlag),
    .ProgCtr      (ProgCtr),
    .Busy         (Busy),
    .Done         (Done),
    .InstCount    (InstCount)
  );

  always #5 Clk = ~Clk;

  task automatic model_reset();
    m_state = 0;
    m_pc    = 0;
    m_cnt   = 0;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
  endtask

  task automatic clear_inputs();
    Start = 0; Ack = 0; JumpEqual = 0; JumpNotEqual = 0;
    OffsetEn = 0; PCRegSelect = 2'd0; OffsetData = 8'd0; ZeroFlag = 0;
  endtask

  // Advance the model from the current inputs, then clock the DUT.
  task automatic tick();
    int sel;
    bit taken;
    sel = int'(PCRegSelect);
    if (m_state != 1) begin
      if (Start) begin
        m_state = 1;
        m_pc    = int'(StartAddr);
        m_cnt   = 0;
      end
    end else if (Ack) begin
      m_state = 2;
    end else begin
      taken = (JumpEqual && ZeroFlag) || (JumpNotEqual && !ZeroFlag);
      if (sel != 0 && taken) begin
        m_pc = m_reg[sel];
      end else begin
        if (sel != 0 && !JumpEqual && !JumpNotEqual)
          m_reg[sel] = (m_pc + 1 + (OffsetEn ? int'(OffsetData) : 0)) % PC_MOD;
        m_pc = (m_pc + 1) % PC_MOD;
      end
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    ResetN = 0;
    StartAddr = '0;
    model_reset();
    #1;
    checks++;
    if (ProgCtr !== 10'h000 || Busy !== 1'b0 || Done !== 1'b0 || InstCount !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: pc=%h busy=%b done=%b cnt=%h required pc=000 busy=0 done=0 cnt=0000",
               ProgCtr, Busy, Done, InstCount);
    end
    @(posedge Clk); #1;
    ResetN = 1;
    // Run into RUN, fill two save registers, land at 0x025, then reset asynchronously
    StartAddr = 10'h023; Start = 1; tick(); Start = 0;
    PCRegSelect = 2'd1; tick();
    PCRegSelect = 2'd3; OffsetEn = 1; OffsetData = 8'd5; tick();
    clear_inputs();
    checks++;
    if (ProgCtr !== 10'h025 || dut.u_save.r_pcreg[3] !== 10'h02A || Busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_prep: pc=%h pcreg3=%h busy=%b required pc=025 pcreg3=02a busy=1",
               ProgCtr, dut.u_save.r_pcreg[3], Busy);
    end
    #2 ResetN = 0;
    model_reset();
    #1;
    checks++;
    if (ProgCtr !== 10'h000 || Busy !== 1'b0 || Done !== 1'b0 ||
        dut.u_save.r_pcreg[1] !== 10'h000 || dut.u_save.r_pcreg[2] !== 10'h000 ||
        dut.u_save.r_pcreg[3] !== 10'h000) begin
      errors++;
      $display("FAIL reset_midrun: pc=%h busy=%b done=%b regs=%h/%h/%h required all zero",
               ProgCtr, Busy, Done, dut.u_save.r_pcreg[1], dut.u_save.r_pcreg[2], dut.u_save.r_pcreg[3]);
    end
    @(posedge Clk); #1;
    ResetN = 1;
  endtask

  task automatic test_plain_run();
    clear_inputs();
    StartAddr = 10'h010; Start = 1; tick(); Start = 0;
    for (int i = 0; i <= 5; i++) begin
      checks++;
      if (ProgCtr !== 10'(10'h010 + i) || Busy !== 1'b1 || Done !== 1'b0) begin
        errors++;
        $display("FAIL plain_pc[%0d]: pc=%h busy=%b done=%b required pc=%h busy=1 done=0",
                 i, ProgCtr, Busy, Done, 10'(10'h010 + i));
      end
      if (i < 5) tick();
    end
    Ack = 1; tick(); Ack = 0;
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b0 || InstCount !== 16'd5 || ProgCtr !== 10'h015) begin
      errors++;
      $display("FAIL plain_halt: done=%b busy=%b cnt=%0d pc=%h required done=1 busy=0 cnt=5 pc=015",
               Done, Busy, InstCount, ProgCtr);
    end
    JumpNotEqual = 1; PCRegSelect = 2'd1; tick(); tick(); clear_inputs();
    checks++;
    if (Done !== 1'b1 || ProgCtr !== 10'h015 || InstCount !== 16'd5) begin
      errors++;
      $display("FAIL halt_hold: done=%b pc=%h cnt=%0d required done=1 pc=015 cnt=5", Done, ProgCtr, InstCount);
    end
  endtask

  task automatic test_save_jump();
    clear_inputs();
    StartAddr = 10'h020; Start = 1; tick(); Start = 0;
    PCRegSelect = 2'd2; OffsetEn = 1; OffsetData = 8'h07; tick();
    clear_inputs();
    checks++;
    if (dut.u_save.r_pcreg[2] !== 10'h028 || ProgCtr !== 10'h021 || Done !== 1'b0) begin
      errors++;
      $display("FAIL spc_offset: pcreg2=%h pc=%h done=%b required pcreg2=028 pc=021 done=0",
               dut.u_save.r_pcreg[2], ProgCtr, Done);
    end
    JumpEqual = 1; PCRegSelect = 2'd2; ZeroFlag = 1; tick(); clear_inputs();
    checks++;
    if (ProgCtr !== 10'h028) begin
      errors++;
      $display("FAIL je_taken: pc=%h required 028", ProgCtr);
    end
  endtask

  task automatic test_jne_cases();
    clear_inputs();
    PCRegSelect = 2'd1; OffsetEn = 1; OffsetData = 8'h10; tick(); clear_inputs();
    checks++;
    if (dut.u_save.r_pcreg[1] !== 10'h039 || ProgCtr !== 10'h029) begin
      errors++;
      $display("FAIL spc_reg1: pcreg1=%h pc=%h required pcreg1=039 pc=029", dut.u_save.r_pcreg[1], ProgCtr);
    end
    JumpNotEqual = 1; PCRegSelect = 2'd1; ZeroFlag = 1; tick();
    checks++;
    if (ProgCtr !== 10'h02A || dut.u_save.r_pcreg[1] !== 10'h039) begin
      errors++;
      $display("FAIL jne_not_taken: pc=%h pcreg1=%h required pc=02a pcreg1=039", ProgCtr, dut.u_save.r_pcreg[1]);
    end
    ZeroFlag = 0; tick();
    checks++;
    if (ProgCtr !== 10'h039) begin
      errors++;
      $display("FAIL jne_taken: pc=%h required 039", ProgCtr);
    end
    clear_inputs();
    JumpEqual = 1; PCRegSelect = 2'd0; ZeroFlag = 1; tick(); clear_inputs();
    checks++;
    if (ProgCtr !== 10'h03A) begin
      errors++;
      $display("FAIL je_sel0: pc=%h required 03a", ProgCtr);
    end
    Ack = 1; tick(); Ack = 0;
  endtask

  task automatic test_wrap();
    clear_inputs();
    StartAddr = 10'h3FE; Start = 1; tick(); Start = 0;
    PCRegSelect = 2'd3; OffsetEn = 0; OffsetData = 8'h55; tick();
    checks++;
    if (dut.u_save.r_pcreg[3] !== 10'h3FF || ProgCtr !== 10'h3FF) begin
      errors++;
      $display("FAIL save_no_offset: pcreg3=%h pc=%h required pcreg3=3ff pc=3ff", dut.u_save.r_pcreg[3], ProgCtr);
    end
    PCRegSelect = 2'd1; OffsetEn = 1; OffsetData = 8'hFF; tick(); clear_inputs();
    checks++;
    if (dut.u_save.r_pcreg[1] !== 10'h0FF || ProgCtr !== 10'h000) begin
      errors++;
      $display("FAIL save_wrap: pcreg1=%h pc=%h required pcreg1=0ff pc=000", dut.u_save.r_pcreg[1], ProgCtr);
    end
  endtask

  task automatic test_start_in_run_and_halt();
    clear_inputs();
    StartAddr = 10'h100; Start = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (ProgCtr !== 10'(i) || Busy !== 1'b1) begin
        errors++;
        $display("FAIL start_in_run[%0d]: pc=%h busy=%b required pc=%h busy=1", i, ProgCtr, Busy, 10'(i));
      end
    end
    Ack = 1; tick(); Ack = 0;
    checks++;
    if (Done !== 1'b1 || InstCount !== 16'd5) begin
      errors++;
      $display("FAIL halt_after_run: done=%b cnt=%0d required done=1 cnt=5", Done, InstCount);
    end
    tick(); Start = 0;
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b1 || ProgCtr !== 10'h100 || InstCount !== 16'd0 ||
        dut.u_save.r_pcreg[1] !== 10'h0FF || dut.u_save.r_pcreg[2] !== 10'h028 ||
        dut.u_save.r_pcreg[3] !== 10'h3FF) begin
      errors++;
      $display("FAIL restart_from_halt: done=%b busy=%b pc=%h cnt=%0d regs=%h/%h/%h required 0 1 100 0 0ff/028/3ff",
               Done, Busy, ProgCtr, InstCount,
               dut.u_save.r_pcreg[1], dut.u_save.r_pcreg[2], dut.u_save.r_pcreg[3]);
    end
    Ack = 1; tick(); Ack = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      Start        = ($urandom_range(0, 9) == 0);
      StartAddr    = 10'($urandom);
      Ack          = ($urandom_range(0, 29) == 0);
      JumpEqual    = ($urandom_range(0, 3) == 0);
      JumpNotEqual = ($urandom_range(0, 3) == 0);
      OffsetEn     = 1'($urandom);
      PCRegSelect  = 2'($urandom);
      OffsetData   = 8'($urandom);
      ZeroFlag     = 1'($urandom);
      tick();
      checks++;
      if (ProgCtr !== 10'(m_pc) || InstCount !== 16'(m_cnt) ||
          Busy !== (m_state == 1) || Done !== (m_state == 2) ||
          dut.u_save.r_pcreg[1] !== 10'(m_reg[1]) || dut.u_save.r_pcreg[2] !== 10'(m_reg[2]) ||
          dut.u_save.r_pcreg[3] !== 10'(m_reg[3])) begin
        errors++;
        $display("FAIL random[%0d]: pc=%h cnt=%0d busy=%b done=%b regs=%h/%h/%h required pc=%h cnt=%0d busy=%b done=%b regs=%h/%h/%h",
                 n, ProgCtr, InstCount, Busy, Done,
                 dut.u_save.r_pcreg[1], dut.u_save.r_pcreg[2], dut.u_save.r_pcreg[3],
                 10'(m_pc), m_cnt, (m_state == 1), (m_state == 2), m_reg[1], m_reg[2], m_reg[3]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_saturate();
    clear_inputs();
    if (m_state == 1) begin
      Ack = 1; tick(); Ack = 0;
    end
    StartAddr = 10'h000; Start = 1; tick(); Start = 0;
    for (int i = 0; i < CNT_MAX + 3; i++) tick();
    checks++;
    if (InstCount !== 16'hFFFF || ProgCtr !== 10'(m_pc)) begin
      errors++;
      $display("FAIL cnt_saturate: cnt=%h pc=%h required cnt=ffff pc=%h", InstCount, ProgCtr, 10'(m_pc));
    end
    Ack = 1; tick(); Ack = 0;
    checks++;
    if (InstCount !== 16'hFFFF || Done !== 1'b1) begin
      errors++;
      $display("FAIL cnt_sat_halt: cnt=%h done=%b required cnt=ffff done=1", InstCount, Done);
    end
  endtask

  initial begin
    test_reset();
    test_plain_run();
    test_save_jump();
    test_jne_cases();
    test_wrap();
    test_start_in_run_and_halt();
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_seq.md
# fetch_seq

Program sequencer and program counter for the 9-bit core. Owns the PC, the three jump-target save registers (PCreg1–3) and the start/done handshake with the testbench. Consumes the decoder's jump/save/halt controls and the ALU zero flag, and addresses the instruction ROM. One program runs per Start pulse; the block halts on the all-ones instruction.

## Interface
Parameters:
- PC_W, 10, PC and save-register width (instruction ROM depth 2^PC_W)
- CNT_W, 16, width of the executed-instruction counter

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- ResetN  in  1  reset; one clock, asynchronous, active-low
- Start  in  1  begin program at StartAddr (level sampled each edge)
- StartAddr  in  PC_W  first instruction address
- Ack  in  1  decoder halt indication (instruction == 9'h1FF)
- JumpEqual  in  1  decoder: je
- JumpNotEqual  in  1  decoder: jne
- OffsetEn  in  1  decoder: add offset when saving
- PCRegSelect  in  2  decoder: 00 none, 01/10/11 = PCreg1/2/3
- OffsetData  in  8  unsigned offset (r8 read port B)
- ZeroFlag  in  1  registered ALU zero flag
- ProgCtr  out  PC_W  instruction ROM address
- Busy  out  1  state == RUN; decoder outputs valid and may commit
- Done  out  1  program halted
- InstCount  out  CNT_W  instructions executed in the current/last run

## Operation
- States: IDLE, RUN, HALT.
- IDLE:
  - Start=1 → ProgCtr<=StartAddr, InstCount<=0, go RUN.
  - Otherwise all registers hold.
- RUN, evaluated each edge in priority order:
  1. Ack=1 → go HALT, Done<=1, ProgCtr holds. The halt instruction is not counted.
  2. Taken jump: (JumpEqual & ZeroFlag) | (JumpNotEqual & ~ZeroFlag), with PCRegSelect≠0 → ProgCtr<=PCreg[PCRegSelect].
  3. Otherwise ProgCtr<=ProgCtr+1, mod 2^PC_W. All-ones wraps to 0.
- Jump with PCRegSelect=00 is never taken; falls to PC+1.
- Save (spc) in RUN: PCRegSelect≠0 & ~JumpEqual & ~JumpNotEqual → PCreg[sel] <= ProgCtr + 1 + (OffsetEn ? OffsetData : 0), truncated to PC_W. ProgCtr still advances by 1.
- Save and jump never coincide; the jump case above excludes saves.
- InstCount increments by 1 on every RUN edge without Ack. It saturates at all-ones and never wraps.
- Start in RUN is ignored.
- HALT:
  - Done=1 held; ProgCtr and InstCount hold.
  - Start=1 → same actions as IDLE start, Done<=0, go RUN.
- PCreg1–3 are never cleared by Start; only reset clears them.
- Decoder inputs are ignored outside RUN.

## Timing
- Reset (ResetN=0, async): state=IDLE, ProgCtr=0, PCreg1–3=0, InstCount=0, Done=0, Busy=0.
- ResetN deassertion is synchronised externally. Reset mid-RUN aborts the program immediately; no Done.
- Start sampled at edge t → ProgCtr=StartAddr and Busy=1 from t+; first instruction decodes during cycle t..t+1.
- Single-cycle instructions: one PC update per RUN cycle, no stalls.
- Jump target visible on ProgCtr the cycle after the jump is decoded. A save's new value is usable by a jump in the very next cycle.
- Ack at edge t → Busy=0 and Done=1 from t+.
- Busy and Done are decoded from the state register, so glitch-free. Never both high.

## Structure
- Shared definitions package gets:
  - typedef enum logic [1:0] fetch_state_t {FS_IDLE, FS_RUN, FS_HALT}
  - localparam PC_W_DEFAULT=10
  - localparam PCSEL_NONE=2'b00
- Sub-module pc_save_file:
  - three PC_W registers, async active-low reset
  - write port (sel, data, en) and one combinational read port by sel
  - sel=00 reads 0
- fetch_seq holds the FSM, PC, counter, and next-PC/save arithmetic.

## Test plan
- Reset mid-RUN (ProgCtr=0x025) → ProgCtr=0, Busy=0, Done=0, PCreg1–3=0 without a clock edge.
- Start, StartAddr=0x010, five plain instructions then Ack → ProgCtr 0x010..0x015, Done=1 after the Ack edge, InstCount=5, ProgCtr holds 0x015.
- At ProgCtr=0x020: spc sel=10 with OffsetEn=1, OffsetData=0x07 → PCreg2=0x028. Next cycle je sel=10 with ZeroFlag=1 → ProgCtr=0x028.
- jne sel=01 with ZeroFlag=1 → not taken, ProgCtr+1. Same with ZeroFlag=0 → PCreg1. je with sel=00 and ZeroFlag=1 → PC+1.
- PC wrap: StartAddr=0x3FF, no jump → ProgCtr=0x000. Save at 0x3FE, no offset → PCreg=0x3FF. Save at 0x3FF with OffsetData=0xFF → PCreg=0x0FF.
- Start held during RUN → no restart. Start in HALT → Done=0, ProgCtr=StartAddr, InstCount=0, PCreg contents retained. Force InstCount near all-ones → saturates at 0xFFFF.
